// File: rtl/fake_n64_controller_tx_if.sv
// Joybus transmit request/status bundle between the command decoder (master)
// and the controller-side transmitter (slave).
interface fake_n64_controller_tx_if #(
  parameter int MAX_BYTES = 4
);
  logic                   start;
  logic [2:0]             byte_count;
  logic [8*MAX_BYTES-1:0] tx_data;
  logic                   data_oe;
  logic                   busy;
  logic                   done;

  modport master (
    output start,
    output byte_count,
    output tx_data,
    input  data_oe,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  byte_count,
    input  tx_data,
    output data_oe,
    output busy,
    output done
  );
endinterface

// File: rtl/fake_n64_controller_tx.sv
// Controller-side N64 joybus transmitter: sends the top byte_count bytes of tx_data MSB first
// on an open-drain line (data_oe=1 pulls low). All outputs registered; start ignored while busy.
module fake_n64_controller_tx #(
  parameter int CLKS_PER_US   = 16,
  parameter int MAX_BYTES     = 4,
  parameter int TURNAROUND_US = 2,
  parameter int STOP_LOW_US   = 2
) (
  input  logic                    sample_clk,
  input  logic                    reset_n,
  fake_n64_controller_tx_if.slave bus
);

  localparam int DW        = 8 * MAX_BYTES;
  localparam int US_W      = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int SLOT_MAX0 = (TURNAROUND_US > STOP_LOW_US) ? TURNAROUND_US : STOP_LOW_US;
  localparam int SLOT_MAX  = (SLOT_MAX0 > 4) ? SLOT_MAX0 : 4;
  localparam int SLOT_W    = $clog2(SLOT_MAX);
  localparam int BL_W      = $clog2(DW + 1);

  localparam logic [US_W-1:0]   US_LAST        = US_W'(CLKS_PER_US - 1);
  localparam logic [SLOT_W-1:0] SLOT_TURN_LAST = SLOT_W'(TURNAROUND_US - 1);
  localparam logic [SLOT_W-1:0] SLOT_BIT_LAST  = SLOT_W'(3);
  localparam logic [SLOT_W-1:0] SLOT_STOP_LAST = SLOT_W'(STOP_LOW_US - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    BIT  = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [US_W-1:0]   us_cnt_q, us_cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [DW-1:0]     shift_q, shift_d;
  logic              data_oe_q, data_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              us_wrap;
  logic [US_W-1:0]   us_next;
  logic              start_ok;

  assign us_wrap  = (us_cnt_q == US_LAST);
  assign us_next  = us_wrap ? '0 : us_cnt_q + US_W'(1);
  assign start_ok = bus.start && (bus.byte_count != 3'd0) &&
                    (int'(bus.byte_count) <= MAX_BYTES);

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      us_cnt_q    <= '0;
      slot_q      <= '0;
      bits_left_q <= '0;
      shift_q     <= '0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      us_cnt_q    <= us_cnt_d;
      slot_q      <= slot_d;
      bits_left_q <= bits_left_d;
      shift_q     <= shift_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    us_cnt_d    = us_cnt_q;
    slot_d      = slot_q;
    bits_left_d = bits_left_q;
    shift_d     = shift_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d     = TURN;
          us_cnt_d    = '0;
          slot_d      = '0;
          shift_d     = bus.tx_data;
          bits_left_d = BL_W'({bus.byte_count, 3'b000});
        end
      end
      TURN: begin
        us_cnt_d = us_next;
        if (us_wrap) begin
          if (slot_q == SLOT_TURN_LAST) begin
            slot_d  = '0;
            state_d = BIT;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      BIT: begin
        us_cnt_d = us_next;
        if (us_wrap) begin
          if (slot_q == SLOT_BIT_LAST) begin
            slot_d      = '0;
            shift_d     = shift_q << 1;
            bits_left_d = bits_left_q - BL_W'(1);
            if (bits_left_q == BL_W'(1)) begin
              state_d = STOP;
            end
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      STOP: begin
        us_cnt_d = us_next;
        if (us_wrap) begin
          if (slot_q == SLOT_STOP_LAST) begin
            slot_d  = '0;
            state_d = IDLE;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so the flops line up exactly with the state they describe.
  always_comb begin
    data_oe_d = 1'b0;
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      BIT: begin
        if (slot_d == SLOT_W'(0)) begin
          data_oe_d = 1'b1;
        end else if (slot_d == SLOT_W'(1) || slot_d == SLOT_W'(2)) begin
          data_oe_d = ~shift_d[DW-1];
        end else begin
          data_oe_d = 1'b0;
        end
      end
      STOP:    data_oe_d = 1'b1;
      default: data_oe_d = 1'b0;
    endcase
  end

  assign bus.data_oe = data_oe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
